// File: rtl/regfile_sb_if.sv
// Bus between issue/writeback logic (master) and the scoreboarded register file (slave).
// Carries the read ports, both write ports, the claim port and the live busy count.
interface regfile_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int CNT_WIDTH  = ADDR_WIDTH
);
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic                         wr0_en;
  logic [ADDR_WIDTH-1:0]        wr0_addr;
  logic [DATA_WIDTH-1:0]        wr0_data;
  logic                         wr1_en;
  logic [ADDR_WIDTH-1:0]        wr1_addr;
  logic [DATA_WIDTH-1:0]        wr1_data;
  logic                         claim_en;
  logic [ADDR_WIDTH-1:0]        claim_addr;
  logic [CNT_WIDTH-1:0]         busy_count;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           claim_en, claim_addr,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           claim_en, claim_addr,
    output rd_data, rd_busy, busy_count
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational reads, two prioritised writes and a busy scoreboard.
// Optional write-to-read forwarding when REGFILE_SB_BYPASS_EN is defined.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int CNT_WIDTH  = ADDR_WIDTH
) (
  input logic          clk,
  input logic          rst,
  regfile_sb_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [NREG];
  logic [NREG-1:0]       r_busy;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_wr0_vld;
  logic                  w_wr1_vld;
  logic                  w_claim_vld;
  logic                  w_clr0;
  logic                  w_clr1;
  logic                  w_set;
  logic [NREG-1:0]       w_busy_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_ra;
  logic [NUM_RD*DATA_WIDTH-1:0] w_rd_data;
  logic [NUM_RD-1:0]     w_rd_busy;

  assign w_wr0_vld   = bus.wr0_en   && (bus.wr0_addr   != '0);
  assign w_wr1_vld   = bus.wr1_en   && (bus.wr1_addr   != '0);
  assign w_claim_vld = bus.claim_en && (bus.claim_addr != '0);

  // Count tracks the busy vector incrementally: a clear is suppressed when the claim
  // re-sets the same bit, and a dual write to one address clears only once.
  always_comb begin
    w_clr0 = w_wr0_vld && r_busy[bus.wr0_addr] &&
             !(w_claim_vld && (bus.claim_addr == bus.wr0_addr));
    w_clr1 = w_wr1_vld && r_busy[bus.wr1_addr] &&
             !(w_wr0_vld && (bus.wr0_addr == bus.wr1_addr)) &&
             !(w_claim_vld && (bus.claim_addr == bus.wr1_addr));
    w_set  = w_claim_vld && !r_busy[bus.claim_addr];
    w_busy_nxt = r_busy;
    if (w_wr0_vld)   w_busy_nxt[bus.wr0_addr]   = 1'b0;
    if (w_wr1_vld)   w_busy_nxt[bus.wr1_addr]   = 1'b0;
    if (w_claim_vld) w_busy_nxt[bus.claim_addr] = 1'b1;
    w_cnt_nxt = r_cnt - CNT_WIDTH'(w_clr0) - CNT_WIDTH'(w_clr1) + CNT_WIDTH'(w_set);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr0_vld) r_mem[bus.wr0_addr] <= bus.wr0_data;
      if (w_wr1_vld) r_mem[bus.wr1_addr] <= bus.wr1_data;
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    w_ra      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_ra = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (w_ra != '0) begin
        w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_ra];
        w_rd_busy[k] = r_busy[w_ra];
`ifdef REGFILE_SB_BYPASS_EN
        if (w_wr1_vld && (bus.wr1_addr == w_ra)) begin
          w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr1_data;
          w_rd_busy[k] = w_claim_vld && (bus.claim_addr == w_ra);
        end else if (w_wr0_vld && (bus.wr0_addr == w_ra)) begin
          w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr0_data;
          w_rd_busy[k] = w_claim_vld && (bus.claim_addr == w_ra);
        end
`else
`endif
      end
    end
  end

  assign bus.rd_data    = w_rd_data;
  assign bus.rd_busy    = w_rd_busy;
  assign bus.busy_count = r_cnt;
endmodule
